main_memory_model: RTL and testbench

- Multi-cycle main-memory slave that sits directly downstream of the cache control FSM.
- Consumes the FSM's MStrobe/MRW request and returns a full cache line after a fixed latency, with a one-cycle MReady pulse.
- Holds line-organised storage.
- Used in simulation and FPGA builds as the backing store for the direct-mapped cache.

---
 rtl/main_memory_model.sv | 66 ++++++
 tb/tb_main_memory_model.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_model.sv
// main_memory_model: fixed-latency line memory slave behind the cache FSM; define MEM_DROP_CNT_EN to add the DropCnt counter
module main_memory_model #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY = 4
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MStrobe,
  input  logic                         MRW,
  input  logic [ADDR_W-1:0]            MAddr,
  input  logic [LINE_WORDS*DATA_W-1:0] MDataIn,
  output logic [LINE_WORDS*DATA_W-1:0] MDataOut,
  output logic                         MReady,
  output logic                         Busy
`ifdef MEM_DROP_CNT_EN
  ,
  output logic [7:0]                   DropCnt
`endif
);
  localparam int LW = LINE_WORDS*DATA_W;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic [ADDR_W-1:0] req_addr;
  logic req_rw;
  logic [LW-1:0] req_data;
  logic [LW-1:0] mem [2**ADDR_W];
  logic accept, commit;
  // next state and status outputs; the unused encoding falls back to IDLE
  always_comb begin
    accept = MStrobe && (state == IDLE || state == DONE);
    commit = state == WAIT && cnt == 8'd0;
    MReady = state == DONE;
    Busy = state == WAIT;
    state_nxt = accept ? WAIT : commit ? DONE : state == WAIT ? WAIT : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // request latch, latency counter and registered read data
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= 8'd0;
      MDataOut <= '0;
    end else begin
      if (accept) begin
        cnt <= 8'(LATENCY - 2);
        req_addr <= MAddr;
        req_rw <= MRW;
        req_data <= MDataIn;
      end else if (state == WAIT && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (commit && req_rw) MDataOut <= mem[req_addr];
    end
  // line storage survives reset; a write only commits on the edge entering DONE
  always_ff @(posedge clk)
    if (reset && commit && !req_rw) mem[req_addr] <= req_data;
`ifdef MEM_DROP_CNT_EN
  // saturating count of strobes ignored while busy
  always_ff @(posedge clk)
    if (!reset) DropCnt <= 8'd0;
    else if (Busy && MStrobe && DropCnt != 8'hFF) DropCnt <= DropCnt + 8'd1;
`endif
endmodule

// File: tb/tb_main_memory_model.sv
// tb_main_memory_model: directed stimulus with a cycle-timed reference model of the memory slave
module tb_main_memory_model;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic reset, MStrobe, MRW;
  logic [9:0] MAddr;
  logic [127:0] MDataIn, MDataOut;
  logic MReady, Busy;
`ifdef MEM_DROP_CNT_EN
  logic [7:0] DropCnt;
  logic s_reset, s_strobe, s_ready, s_busy;
  logic [127:0] s_dout;
  logic [7:0] s_drop;
`endif
  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int cyc = 0, t0 = 0, m_drop = 0;
  bit pend = 1'b0;
  logic p_rw;
  logic [9:0] p_addr;
  logic [127:0] p_data;
  logic [127:0] m_dout = '0;
  logic [127:0] mmem [int];
  logic exp_ready, exp_busy;
  localparam logic [127:0] L1 = 128'h044A3322_11223344_DEADBEEF_00000001;
  localparam logic [127:0] LA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] LF = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] L12 = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
  localparam logic [127:0] P1 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] P2 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] P3 = 128'h33333333_33333333_33333333_33333333;

  main_memory_model #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(MDataOut), .MReady(MReady), .Busy(Busy)
`ifdef MEM_DROP_CNT_EN
    , .DropCnt(DropCnt)
`endif
  );
`ifdef MEM_DROP_CNT_EN
  main_memory_model #(.LATENCY(255)) sat (
    .clk(clk), .reset(s_reset), .MStrobe(s_strobe), .MRW(1'b1), .MAddr(10'd0),
    .MDataIn(128'd0), .MDataOut(s_dout), .MReady(s_ready), .Busy(s_busy), .DropCnt(s_drop)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // model: a request taken in cycle t0 is busy in t0+1..t0+LAT-1, acts on the edge ending t0+LAT-1, readies in t0+LAT
  always @(negedge clk) begin
    exp_ready = pend && cyc == t0 + LAT;
    exp_busy = pend && cyc > t0 && cyc < t0 + LAT;
    if (chk_en) begin
      chk("ready", MReady, exp_ready);
      chk("busy", Busy, exp_busy);
      chk("dout", MDataOut, m_dout);
`ifdef MEM_DROP_CNT_EN
      chk("dropcnt", DropCnt, 128'(m_drop));
`endif
    end
    if (!reset) begin
      pend = 1'b0;
      m_dout = '0;
      m_drop = 0;
    end else begin
      if (exp_busy && MStrobe && m_drop < 255) m_drop++;
      if (pend && cyc == t0 + LAT - 1) begin
        if (p_rw) m_dout = mmem[int'(p_addr)];
        else mmem[int'(p_addr)] = p_data;
      end
      if (pend && cyc >= t0 + LAT) pend = 1'b0;
      if (!exp_busy && MStrobe) begin
        pend = 1'b1;
        t0 = cyc;
        p_rw = MRW;
        p_addr = MAddr;
        p_data = MDataIn;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rw, input logic [9:0] a, input logic [127:0] d);
    MStrobe = s;
    MRW = rw;
    MAddr = a;
    MDataIn = d;
  endtask

  task automatic req(input logic rw, input logic [9:0] a, input logic [127:0] d);
    drive(1'b1, rw, a, d);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    repeat (LAT) step();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 10'd0, '0);
`ifdef MEM_DROP_CNT_EN
    s_reset = 1'b0;
    s_strobe = 1'b0;
`endif
    step();
    step();
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", MReady, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_dout", MDataOut, '0);
    step();
    // write then read
    drive(1'b1, 1'b0, 10'd5, L1);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    chk("t1_busy_c1", Busy, 1'b1);
    repeat (3) step();
    chk("t1_ready_c4", MReady, 1'b1);
    chk("t1_busy_c4", Busy, 1'b0);
    step();
    drive(1'b1, 1'b1, 10'd5, '0);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    chk("t1_busy_c6", Busy, 1'b1);
    repeat (3) step();
    chk("t1_ready_c9", MReady, 1'b1);
    chk("t1_dout_c9", MDataOut, L1);
    step();
    // back-to-back read strobed in the write's DONE cycle
    drive(1'b1, 1'b0, 10'd7, LA);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    repeat (3) step();
    chk("t2_ready_c4", MReady, 1'b1);
    drive(1'b1, 1'b1, 10'd7, '0);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    chk("t2_busy_c5", Busy, 1'b1);
    repeat (3) step();
    chk("t2_ready_c8", MReady, 1'b1);
    chk("t2_dout_c8", MDataOut, LA);
    step();
    // dropped strobe during a read
    req(1'b0, 10'd1, P1);
    req(1'b0, 10'd2, P2);
    drive(1'b1, 1'b1, 10'd1, '0);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    step();
    drive(1'b1, 1'b0, 10'd2, LF);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
`ifdef MEM_DROP_CNT_EN
    chk("t3_dropcnt", DropCnt, 128'd1);
`endif
    step();
    chk("t3_ready_c4", MReady, 1'b1);
    chk("t3_dout_c4", MDataOut, P1);
    step();
    chk("t3_ready_c5", MReady, 1'b0);
    req(1'b1, 10'd2, '0);
    chk("t3_mem2", MDataOut, P2);
    // reset mid-write discards it
    req(1'b0, 10'd3, P3);
    drive(1'b1, 1'b0, 10'd3, LF);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t4_busy", Busy, 1'b0);
    chk("t4_ready", MReady, 1'b0);
    repeat (4) step();
    req(1'b1, 10'd3, '0);
    chk("t4_mem3", MDataOut, P3);
    // reset in DONE keeps the committed write
    drive(1'b1, 1'b0, 10'd9, L12);
    step();
    drive(1'b0, 1'b0, 10'd0, '0);
    repeat (3) step();
    chk("t5_ready_c4", MReady, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_dout_rst", MDataOut, '0);
    chk("t5_ready_rst", MReady, 1'b0);
    step();
    req(1'b1, 10'd9, '0);
    chk("t5_mem9", MDataOut, L12);
`ifdef MEM_DROP_CNT_EN
    // drop counter saturation with a long latency
    s_reset = 1'b1;
    s_strobe = 1'b1;
    repeat (300) step();
    chk("t6_sat", s_drop, 128'd255);
    s_strobe = 1'b0;
    s_reset = 1'b0;
    step();
    s_reset = 1'b1;
    chk("t6_clear", s_drop, 128'd0);
`endif
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
